// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction-fetch and load/store word
// requests onto the 8-bit synchronous RAM/IO bus, with IO back-pressure, pause and flush.
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state, state_nx;
  logic [31:0] base, base_nx;
  logic [2:0]  len, len_nx;
  logic [2:0]  issue, issue_nx;
  logic [2:0]  cap, cap_nx;
  logic        is_if, is_if_nx;
  logic [31:0] wdata, wdata_nx;
  logic [31:0] buffer, buffer_nx;
  logic        pend, pend_nx;
  logic        if_done_q, if_done_nx;
  logic        d_done_q, d_done_nx;
  logic [31:0] if_data_nx, d_rdata_nx;

  logic [31:0] cur_addr;
  logic        cur_io;
  logic        rd_issue;
  logic        wr_issue;

  assign cur_addr = base + {29'b0, issue};
  assign cur_io   = (cur_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign rd_issue = (state == READ) && (issue < len) && rdy_in;
  assign wr_issue = (state == WRITE) && (issue < len) && rdy_in && !(cur_io && io_buffer_full);

  // Bus is parked at address 0 whenever nothing is issued, so an IO address never lingers.
  assign mem_a    = (rd_issue || wr_issue) ? cur_addr : 32'h0;
  assign mem_wr   = wr_issue;
  assign mem_dout = wr_issue ? wdata[{issue[1:0], 3'b000} +: 8] : 8'h00;

  // A done pulse raised while paused is held and presented once the bus resumes.
  assign if_done = if_done_q && rdy_in;
  assign d_done  = d_done_q && rdy_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= 32'h0;
      len       <= 3'd0;
      issue     <= 3'd0;
      cap       <= 3'd0;
      is_if     <= 1'b0;
      wdata     <= 32'h0;
      buffer    <= 32'h0;
      pend      <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if_data   <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      state     <= state_nx;
      base      <= base_nx;
      len       <= len_nx;
      issue     <= issue_nx;
      cap       <= cap_nx;
      is_if     <= is_if_nx;
      wdata     <= wdata_nx;
      buffer    <= buffer_nx;
      pend      <= pend_nx;
      if_done_q <= if_done_nx;
      d_done_q  <= d_done_nx;
      if_data   <= if_data_nx;
      d_rdata   <= d_rdata_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    base_nx    = base;
    len_nx     = len;
    issue_nx   = issue;
    cap_nx     = cap;
    is_if_nx   = is_if;
    wdata_nx   = wdata;
    buffer_nx  = buffer;
    pend_nx    = rd_issue;
    if_done_nx = if_done_q;
    d_done_nx  = d_done_q;
    if_data_nx = if_data;
    d_rdata_nx = d_rdata;

    if (rdy_in) begin
      if_done_nx = 1'b0;
      d_done_nx  = 1'b0;
    end
    if (flush) if_done_nx = 1'b0;

    case (state)
      IDLE: begin
        if (rdy_in && !if_done_q && !d_done_q) begin
          if (d_req) begin
            state_nx  = d_we ? WRITE : READ;
            is_if_nx  = 1'b0;
            base_nx   = d_addr;
            len_nx    = (d_size == 2'd0) ? 3'd1 : (d_size == 2'd1) ? 3'd2 : 3'd4;
            wdata_nx  = d_wdata;
            issue_nx  = 3'd0;
            cap_nx    = 3'd0;
            buffer_nx = 32'h0;
          end else if (if_req && !flush) begin
            state_nx  = READ;
            is_if_nx  = 1'b1;
            base_nx   = if_addr;
            len_nx    = 3'd4;
            issue_nx  = 3'd0;
            cap_nx    = 3'd0;
            buffer_nx = 32'h0;
          end
        end
      end

      READ: begin
        if (flush && is_if) begin
          state_nx = IDLE;
          pend_nx  = 1'b0;
        end else if (!rdy_in) begin
          // Bytes in flight during a pause are lost; restart at the first uncaptured one.
          issue_nx = cap;
        end else begin
          if (rd_issue) issue_nx = issue + 3'd1;
          if (pend) begin
            buffer_nx[{cap[1:0], 3'b000} +: 8] = mem_din;
            cap_nx = cap + 3'd1;
            if (cap + 3'd1 == len) begin
              state_nx = IDLE;
              pend_nx  = 1'b0;
              if (is_if) begin
                if_done_nx = 1'b1;
                if_data_nx = buffer_nx;
              end else begin
                d_done_nx  = 1'b1;
                d_rdata_nx = buffer_nx;
              end
            end
          end
        end
      end

      WRITE: begin
        if (wr_issue) begin
          issue_nx = issue + 3'd1;
          if (issue + 3'd1 == len) begin
            state_nx  = IDLE;
            d_done_nx = 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model, table of word/byte transfers,
// plus hand-written sequences for arbitration, IO stall, pause, flush and reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_done;
  logic [31:0] if_data;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ram [0:65535];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, IO-space writes are not stored, garbage while paused.
  always @(posedge clk) begin
    if (rst) begin
      ram[16'h1000] = 8'hEF; ram[16'h1001] = 8'hBE;
      ram[16'h1002] = 8'hAD; ram[16'h1003] = 8'hDE;
      ram[16'h0FFF] = 8'h00; ram[16'h0602] = 8'h00; ram[16'h0603] = 8'h00;
      ram[16'hFFFF] = 8'h7A; ram[16'h0000] = 8'h5C;
      mem_din <= 8'h00;
    end else if (rdy_in) begin
      if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] = mem_dout;
      mem_din <= ram[mem_a[15:0]];
    end else begin
      mem_din <= 8'hA5;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, count cycles from the accept edge to the done pulse.
  task automatic xfer(input logic is_if, input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] data);
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wd;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(is_if ? if_done : d_done) && lat < 40);
    data = is_if ? if_data : d_rdata;
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          k;
    int          dk;
    int          ik;
    logic [31:0] data;
    logic        got_d;
    logic        got_if;
    logic        if_first;
    logic        seen;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_1002, 32'h0,          32'h0000_00AD, 3};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_1001, 32'h0,          32'h0000_ADBE, 4};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0600, 32'hAABB_CCDD, 32'h0,         3};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0600, 32'h0,          32'h0000_CCDD, 6};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0601, 32'h1234_5699, 32'h0,         2};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0600, 32'h0,          32'h0000_99DD, 6};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,          32'h0000_5C7A, 4};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_0FFF, 32'h0,          32'hADBE_EF00, 6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    check("rst_dones", {30'b0, if_done, d_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);

    for (int i = 0; i < 11; i++) begin
      xfer(vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, data);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // Simultaneous store and fetch: store goes first, then the fetch.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h2000; d_wdata = 32'h1122_3344;
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk);
    got_d = 1'b0; got_if = 1'b0; if_first = 1'b0; dk = 0; ik = 0; data = 32'h0;
    for (int c = 1; c <= 40 && !got_if; c++) begin
      @(negedge clk);
      if (if_done && !got_d) if_first = 1'b1;
      if (d_done) begin got_d = 1'b1; dk = c; d_req = 1'b0; end
      if (if_done) begin got_if = 1'b1; ik = c; data = if_data; if_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("arb_d_done_cycle", dk, 5);
    check("arb_if_not_first", {31'b0, if_first}, 32'h0);
    check("arb_if_done_cycle", ik, 12);
    check("arb_if_data", data, 32'hDEAD_BEEF);
    check("arb_store_bytes", {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 32'h1122_3344);

    // IO store held off by a full IO buffer for five cycles.
    @(negedge clk);
    io_buffer_full = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h0003_0000; d_wdata = 32'h0000_0041;
    @(posedge clk);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_wr || d_done) seen = 1'b1;
    end
    check("io_no_write_while_full", {31'b0, seen}, 32'h0);
    @(posedge clk);
    #1 io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_write_wr", {31'b0, mem_wr}, 32'h1);
    check("io_write_addr", mem_a, 32'h0003_0000);
    check("io_write_data", {24'b0, mem_dout}, 32'h41);
    check("io_no_early_done", {31'b0, d_done}, 32'h0);
    @(negedge clk);
    check("io_done", {31'b0, d_done}, 32'h1);
    check("io_single_write", {31'b0, mem_wr}, 32'h0);
    d_req = 1'b0;

    // Pause for three cycles right after byte 1 was issued.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pause_byte1_issue", mem_a, 32'h1001);
    @(posedge clk);
    #1 rdy_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_in = 1'b1;
    @(negedge clk);
    check("pause_byte1_reissue", mem_a, 32'h1001);
    k = 6;
    while (!if_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("pause_done_cycle", k, 10);
    check("pause_if_data", if_data, 32'hDEAD_BEEF);
    if_req = 1'b0;

    // Flush while byte 2 of a fetch is on the bus.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("flush_byte2_addr", mem_a, 32'h1002);
    flush = 1'b1; if_req = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_bus_idle", mem_a, 32'h0);
    seen = if_done;
    repeat (6) begin
      @(negedge clk);
      if (if_done) seen = 1'b1;
    end
    check("flush_no_if_done", {31'b0, seen}, 32'h0);
    xfer(1'b1, 1'b0, 2'd2, 32'h1000, 32'h0, lat, data);
    check("flush_refetch_latency", lat, 6);
    check("flush_refetch_data", data, 32'hDEAD_BEEF);

    // Wrapping 2-byte load, reset while byte 1 is on the bus.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    check("wrap_byte0_addr", mem_a, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wrap_byte1_addr", mem_a, 32'h0);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("midrst_bus", {mem_a[30:0], mem_wr}, 32'h0);
    check("midrst_dout_done", {22'b0, mem_dout, if_done, d_done}, 32'h0);
    check("midrst_if_data", if_data, 32'h0);
    check("midrst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
